// File: rtl/iram_mb_if.sv
// AXI4-Lite bus bundle for the iram_mb port-B access path.
// The memory side uses the slave modport; the bus driver uses master.
interface iram_mb_if;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/iram_mb.sv
// Core instruction memory: user RAM (port A fetch, port B AXI4-Lite) plus boot ROM.
// Optional macro IRAM_MB_ERR_RESP_EN enables SLVERR for out-of-range and ROM-write accesses.
module iram_mb #(
  parameter int unsigned           RAM_DEPTH   = 8192,
  parameter int unsigned           ROM_DEPTH   = 2048,
  parameter logic [31:0]           RST_PC      = 32'h0800_0000,
  parameter int unsigned           ROM_SEL_BIT = 27,
  parameter logic [ROM_DEPTH*32-1:0] ROM_INIT  = '0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_n_i,
  input  logic        iram_rd_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        iram_rstn_o,
  iram_mb_if.slave    iram_axi
);

  localparam int unsigned RAM_AW = $clog2(RAM_DEPTH);
  localparam int unsigned ROM_AW = $clog2(ROM_DEPTH);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  logic [31:0] r_ram [RAM_DEPTH];

  logic        r_rstn;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic        r_aw_full, r_w_full, r_awready, r_wready, r_bvalid, r_rvalid;
  logic [31:0] r_aw_addr, r_w_data, r_rdata;
  logic [3:0]  r_w_strb;
  logic [1:0]  r_bresp, r_rresp;

  logic [31:0] w_fetch_addr, w_fetch_data, w_rd_data;
  logic        w_fetch_en;
  logic        w_aw_hs, w_w_hs, w_b_hs, w_ar_hs;
  logic        w_aw_full_d, w_w_full_d, w_bvalid_d;
  logic        w_wr_exec, w_exec_next, w_ram_we, w_arready_c;
  logic        w_wr_err, w_rd_err;

  function automatic logic [31:0] rom_rd(input logic [ROM_AW-1:0] idx);
    return ROM_INIT[32'(idx)*32 +: 32];
  endfunction

  // Port A: the reset PC is forced while the core is held in reset.
  always_comb begin
    w_fetch_addr = r_rstn ? RST_PC : pc_n_i;
    w_fetch_en   = iram_rd_i | r_rstn;
    w_fetch_data = w_fetch_addr[ROM_SEL_BIT] ? rom_rd(w_fetch_addr[ROM_AW+1:2])
                                             : r_ram[w_fetch_addr[RAM_AW+1:2]];
  end

  // Write buffers fill independently; execution waits for both and a free B slot.
  always_comb begin
    w_aw_hs     = iram_axi.awvalid & r_awready;
    w_w_hs      = iram_axi.wvalid & r_wready;
    w_b_hs      = r_bvalid & iram_axi.bready;
    w_wr_exec   = r_aw_full & r_w_full & ~r_bvalid;
    w_aw_full_d = (r_aw_full | w_aw_hs) & ~w_b_hs;
    w_w_full_d  = (r_w_full | w_w_hs) & ~w_b_hs;
    w_bvalid_d  = w_wr_exec | (r_bvalid & ~iram_axi.bready);
    w_exec_next = w_aw_full_d & w_w_full_d & ~w_bvalid_d;
    w_ram_we    = w_wr_exec & ~r_aw_addr[ROM_SEL_BIT] & ~w_wr_err & ~rst;
  end

  // AR also yields the cycle before a write executes, so a write presented with
  // a read in the same cycle is ordered first and the read sees the new data.
  always_comb begin
    w_arready_c = ~rst & ~w_wr_exec & ~w_exec_next & (~r_rvalid | iram_axi.rready);
    w_ar_hs     = iram_axi.arvalid & w_arready_c;
    w_rd_data   = iram_axi.araddr[ROM_SEL_BIT] ? rom_rd(iram_axi.araddr[ROM_AW+1:2])
                                               : r_ram[iram_axi.araddr[RAM_AW+1:2]];
  end

`ifdef IRAM_MB_ERR_RESP_EN
  assign w_wr_err = r_aw_addr[ROM_SEL_BIT]
                  | (32'(r_aw_addr[ROM_SEL_BIT-1:2]) >= RAM_DEPTH);
  assign w_rd_err = 32'(iram_axi.araddr[ROM_SEL_BIT-1:2])
                  >= (iram_axi.araddr[ROM_SEL_BIT] ? ROM_DEPTH : RAM_DEPTH);
`else
  assign w_wr_err = 1'b0;
  assign w_rd_err = 1'b0;
`endif

  // Control and handshake state; reset drops any in-flight transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rstn    <= 1'b1;
      r_pc      <= RST_PC;
      r_aw_full <= 1'b0;
      r_w_full  <= 1'b0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
      r_aw_addr <= '0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
    end else begin
      r_rstn    <= 1'b0;
      if (iram_rd_i & ~r_rstn) r_pc <= pc_n_i;
      r_aw_full <= w_aw_full_d;
      r_w_full  <= w_w_full_d;
      if (w_aw_hs) r_aw_addr <= iram_axi.awaddr;
      if (w_w_hs) begin
        r_w_data <= iram_axi.wdata;
        r_w_strb <= iram_axi.wstrb;
      end
      r_awready <= ~w_aw_full_d & ~w_bvalid_d;
      r_wready  <= ~w_w_full_d & ~w_bvalid_d;
      r_bvalid  <= w_bvalid_d;
      if (w_wr_exec) r_bresp <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
      if (w_ar_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_err ? 32'h0 : w_rd_data;
        r_rresp  <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
      end else if (iram_axi.rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  // Memory array and fetch register; non-blocking updates give read-first collisions.
  always_ff @(posedge clk) begin
    if (w_fetch_en) r_inst <= w_fetch_data;
    if (w_ram_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (r_w_strb[b]) r_ram[r_aw_addr[RAM_AW+1:2]][8*b +: 8] <= r_w_data[8*b +: 8];
      end
    end
  end

  logic w_unused;
  assign w_unused = ^{pc_n_i, iram_axi.awaddr, iram_axi.araddr, iram_axi.awprot,
                      iram_axi.arprot, r_aw_addr};

  assign pc_o             = r_pc;
  assign inst_o           = r_inst;
  assign iram_rstn_o      = r_rstn;
  assign iram_axi.awready = r_awready;
  assign iram_axi.wready  = r_wready;
  assign iram_axi.bvalid  = r_bvalid;
  assign iram_axi.bresp   = r_bresp;
  assign iram_axi.arready = w_arready_c;
  assign iram_axi.rvalid  = r_rvalid;
  assign iram_axi.rdata   = r_rdata;
  assign iram_axi.rresp   = r_rresp;

endmodule
